// File: rtl/canonical_pkg.sv
// Shared types and constants for the canonical-form reduction sequencer.
package canonical_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        CR2   = 3'd4,
        NEXT  = 3'd5,
        FIN   = 3'd6
    } seq_state_t;

    localparam logic PASS_X = 1'b0;
    localparam logic PASS_Z = 1'b1;

endpackage

// File: rtl/canonical_seq_ctrl_if.sv
// Control bundle between the sequencer, the tableau source/collector and the reduction chains.
interface canonical_seq_ctrl_if;

    logic start;
    logic row_valid;
    logic row_ready;
    logic chain_clr;
    logic ld_trans;
    logic ld_store;
    logic second_CR;
    logic second_stage;
    logic feed_zero;
    logic feed_flag;
    logic pass_id;
    logic cap_en;
    logic busy;
    logic done;

    modport master (
        input  start,
        input  row_valid,
        output row_ready,
        output chain_clr,
        output ld_trans,
        output ld_store,
        output second_CR,
        output second_stage,
        output feed_zero,
        output feed_flag,
        output pass_id,
        output cap_en,
        output busy,
        output done
    );

    modport slave (
        output start,
        output row_valid,
        input  row_ready,
        input  chain_clr,
        input  ld_trans,
        input  ld_store,
        input  second_CR,
        input  second_stage,
        input  feed_zero,
        input  feed_flag,
        input  pass_id,
        input  cap_en,
        input  busy,
        input  done
    );

endinterface

// File: rtl/seq_counter.sv
// Row counter shared by FEED, DRAIN and CR2; wraps to zero when it advances from the terminal count.
module seq_counter #(
    parameter int unsigned num_qubit = 4,
    parameter int unsigned CW        = $clog2(num_qubit) + 1
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(num_qubit - 1);

    logic [CW-1:0] cnt;

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/canonical_seq_ctrl.sv
// Two-pass (X-block then Z-block) sequencer for the canonical-form reduction chains.
module canonical_seq_ctrl
    import canonical_pkg::*;
#(
    parameter int unsigned num_qubit = 4,
    parameter int unsigned CW        = $clog2(num_qubit) + 1
) (
    input  logic                 clk,
    input  logic                 rst_new,
    canonical_seq_ctrl_if.master bus
);

    seq_state_t state, state_d;
    logic       pass_q, pass_d;
    logic       tc, accept, cnt_en, cnt_clr;

    // Registered (Moore) controls
    logic clr_q, feed_q, shift_q, cr2_q, ss_q, busy_q, done_q;

    assign accept  = feed_q & bus.row_valid;
    assign cnt_en  = accept | (state == DRAIN) | (state == CR2);
    assign cnt_clr = rst_new | (state == CLR);

    seq_counter #(
        .num_qubit (num_qubit),
        .CW        (CW)
    ) u_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    always_comb begin
        state_d = state;
        pass_d  = pass_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLR;
                    pass_d  = PASS_X;
                end
            end
            CLR:   state_d = FEED;
            FEED:  if (accept && tc) state_d = DRAIN;
            DRAIN: if (tc) state_d = CR2;
            CR2:   if (tc) state_d = (pass_q == PASS_X) ? NEXT : FIN;
            NEXT: begin
                state_d = CLR;
                pass_d  = PASS_Z;
            end
            FIN: begin
                state_d = IDLE;
                pass_d  = PASS_X;
            end
            default: begin
                state_d = IDLE;
                pass_d  = PASS_X;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst_new) begin
            state   <= IDLE;
            pass_q  <= PASS_X;
            clr_q   <= 1'b0;
            feed_q  <= 1'b0;
            shift_q <= 1'b0;
            cr2_q   <= 1'b0;
            ss_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            pass_q  <= pass_d;
            clr_q   <= (state_d == CLR);
            feed_q  <= (state_d == FEED);
            shift_q <= (state_d == DRAIN) || (state_d == CR2);
            cr2_q   <= (state_d == CR2);
            ss_q    <= (state_d != IDLE) && pass_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FIN);
        end
    end

    // FEED strobes follow row_valid directly so the chain shifts on the accepting cycle.
    assign bus.row_ready    = feed_q;
    assign bus.ld_trans     = shift_q | accept;
    assign bus.ld_store     = shift_q | accept;
    assign bus.cap_en       = shift_q | accept;
    assign bus.feed_flag    = accept;
    assign bus.feed_zero    = shift_q;
    assign bus.chain_clr    = clr_q;
    assign bus.second_CR    = cr2_q;
    assign bus.second_stage = ss_q;
    assign bus.pass_id      = pass_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_canonical_seq_ctrl.sv
// Directed bench for canonical_seq_ctrl at num_qubit=4 and num_qubit=2.
module tb_canonical_seq_ctrl;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLR   = 1;
    localparam int PH_FEED  = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_CR2   = 4;
    localparam int PH_NEXT  = 5;
    localparam int PH_FIN   = 6;

    logic clk = 1'b0;
    logic rst4, rst2;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_lt, n_clr, n_cr2, n_busy;

    always #5 clk = ~clk;

    canonical_seq_ctrl_if bus4 ();
    canonical_seq_ctrl_if bus2 ();

    canonical_seq_ctrl #(.num_qubit(4)) dut4 (.clk(clk), .rst_new(rst4), .bus(bus4));
    canonical_seq_ctrl #(.num_qubit(2)) dut2 (.clk(clk), .rst_new(rst2), .bus(bus2));

    // {row_ready, chain_clr, ld_trans, ld_store, second_CR, second_stage,
    //  feed_zero, feed_flag, pass_id, cap_en, busy, done}
    logic [11:0] o4, o2;
    assign o4 = {bus4.row_ready, bus4.chain_clr, bus4.ld_trans, bus4.ld_store, bus4.second_CR,
                 bus4.second_stage, bus4.feed_zero, bus4.feed_flag, bus4.pass_id, bus4.cap_en,
                 bus4.busy, bus4.done};
    assign o2 = {bus2.row_ready, bus2.chain_clr, bus2.ld_trans, bus2.ld_store, bus2.second_CR,
                 bus2.second_stage, bus2.feed_zero, bus2.feed_flag, bus2.pass_id, bus2.cap_en,
                 bus2.busy, bus2.done};

    function automatic string ph_name(input int ph);
        case (ph)
            PH_IDLE:  return "idle";
            PH_CLR:   return "clr";
            PH_FEED:  return "feed";
            PH_DRAIN: return "drain";
            PH_CR2:   return "cr2";
            PH_NEXT:  return "next";
            default:  return "fin";
        endcase
    endfunction

    function automatic logic [11:0] exp_out(input int ph, input bit pass, input bit rv);
        logic rr, clr, lt, cr2, ss, fz, ff, pid, cap, busy, done;
        {rr, clr, lt, cr2, ss, fz, ff, pid, cap, busy, done} = '0;
        if (ph != PH_IDLE) begin
            busy = 1'b1;
            ss   = pass;
            pid  = pass;
        end
        case (ph)
            PH_CLR:   clr = 1'b1;
            PH_FEED:  begin rr = 1'b1; lt = rv; ff = rv; cap = rv; end
            PH_DRAIN: begin lt = 1'b1; fz = 1'b1; cap = 1'b1; end
            PH_CR2:   begin cr2 = 1'b1; lt = 1'b1; fz = 1'b1; cap = 1'b1; end
            PH_FIN:   done = 1'b1;
            default:  ;
        endcase
        return {rr, clr, lt, lt, cr2, ss, fz, ff, pid, cap, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_lt = 0; n_clr = 0; n_cr2 = 0; n_busy = 0;
    endtask

    // One clock cycle: drive at negedge, sample 1 ns later, then advance to the next negedge.
    task automatic cycle(input bit sel, input int ph, input bit pass, input bit rv,
                         input bit st, input bit rs);
        logic [11:0] obs;
        if (sel) begin
            bus2.start = st; bus2.row_valid = rv; rst2 = rs;
        end else begin
            bus4.start = st; bus4.row_valid = rv; rst4 = rs;
        end
        #1;
        obs = sel ? o2 : o4;
        chk($sformatf("%s_p%0d_n%0d", ph_name(ph), pass, sel ? 2 : 4), 32'(obs),
            32'(exp_out(ph, pass, rv)));
        chk("inv_cr2_and_clr", 32'(obs[7] & obs[10]), 32'd0);
        chk("inv_trans_wo_store", 32'(obs[9] & ~obs[8]), 32'd0);
        n_lt   += int'(obs[9]);
        n_clr  += int'(obs[10]);
        n_cr2  += int'(obs[7]);
        n_busy += int'(obs[1]);
        @(posedge clk);
        @(negedge clk);
    endtask

    // fpat lists the row_valid values presented in FEED, LSB first.
    task automatic one_pass(input bit sel, input int n, input bit pass, input bit st,
                            input bit rvo, input logic [7:0] fpat, input int flen);
        cycle(sel, PH_CLR, pass, rvo, st, 1'b0);
        for (int i = 0; i < flen; i++) cycle(sel, PH_FEED, pass, fpat[i], st, 1'b0);
        for (int i = 0; i < n; i++) cycle(sel, PH_DRAIN, pass, rvo, st, 1'b0);
        for (int i = 0; i < n; i++) cycle(sel, PH_CR2, pass, rvo, st, 1'b0);
    endtask

    task automatic full_run(input bit sel, input int n, input bit st, input bit rvo);
        one_pass(sel, n, 1'b0, st, rvo, 8'hff, n);
        cycle(sel, PH_NEXT, 1'b0, rvo, st, 1'b0);
        one_pass(sel, n, 1'b1, st, rvo, 8'hff, n);
        cycle(sel, PH_FIN, 1'b1, rvo, st, 1'b0);
    endtask

    initial begin
        rst4 = 1'b1; rst2 = 1'b1;
        bus4.start = 1'b0; bus4.row_valid = 1'b0;
        bus2.start = 1'b0; bus2.row_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, and start colliding with reset
        cycle(1'b0, PH_IDLE, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal run, num_qubit=4
        clear_counts();
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
        full_run(1'b0, 4, 1'b0, 1'b0);
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nom_busy_cycles", 32'(n_busy), 32'd28);
        chk("nom_ld_cycles", 32'(n_lt), 32'd24);
        chk("nom_clr_cycles", 32'(n_clr), 32'd2);
        chk("nom_cr2_cycles", 32'(n_cr2), 32'd8);

        // FEED stall: row_valid = 1,0,0,1,1,1 in pass 0
        clear_counts();
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
        one_pass(1'b0, 4, 1'b0, 1'b0, 1'b0, 8'b0011_1001, 6);
        cycle(1'b0, PH_NEXT, 1'b0, 1'b0, 1'b0, 1'b0);
        one_pass(1'b0, 4, 1'b1, 1'b0, 1'b0, 8'hff, 4);
        cycle(1'b0, PH_FIN, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_busy_cycles", 32'(n_busy), 32'd30);
        chk("stall_ld_cycles", 32'(n_lt), 32'd24);

        // Reset on the second CR2 cycle of pass 1
        clear_counts();
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
        one_pass(1'b0, 4, 1'b0, 1'b0, 1'b0, 8'hff, 4);
        cycle(1'b0, PH_NEXT, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, PH_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, PH_FEED, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, PH_DRAIN, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, PH_CR2, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, PH_CR2, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, PH_CLR, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, PH_FEED, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

        // start and row_valid held high for a whole run
        clear_counts();
        cycle(1'b0, PH_IDLE, 1'b0, 1'b1, 1'b1, 1'b0);
        full_run(1'b0, 4, 1'b1, 1'b1);
        chk("held_busy_cycles", 32'(n_busy), 32'd28);
        chk("held_ld_cycles", 32'(n_lt), 32'd24);
        cycle(1'b0, PH_IDLE, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, PH_CLR, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, PH_FEED, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

        // num_qubit=2 instance
        clear_counts();
        cycle(1'b1, PH_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
        full_run(1'b1, 2, 1'b0, 1'b0);
        cycle(1'b1, PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("n2_busy_cycles", 32'(n_busy), 32'd16);
        chk("n2_ld_cycles", 32'(n_lt), 32'd12);
        chk("n2_cr2_cycles", 32'(n_cr2), 32'd4);
        chk("n2_clr_cycles", 32'(n_clr), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
